pipelined_arb_mux: RTL and testbench

- Parametrised successor of the datapath 8:1 select mux: NUM_IN channels of WIDTH bits, each with a valid/ready handshake, merged into one registered output.
- Two modes: explicit select, driven by the control unit, or round-robin arbitration.
- One output register stage gives 1-cycle latency and full throughput of 1 transfer/cycle.
- Sits between multiple producers (register-file read ports, forwarding sources, memory return paths) and a single consumer.

---
 rtl/pipelined_arb_mux_pkg.sv | 13 +
 rtl/pipelined_arb_mux_rr_pick.sv | 41 ++++
 rtl/pipelined_arb_mux.sv | 88 ++++++++
 tb/tb_pipelined_arb_mux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_arb_mux_pkg.sv
// Shared definitions for the pipelined arbitrating mux: mode encodings and
// the flattened channel-bus slicing helper.
package pipelined_arb_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Channel idx of a flattened bus occupies bits [lane_lsb(idx, w) +: w].
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pipelined_arb_mux_rr_pick.sv
// Round-robin priority pick: rotate requests so the slot after ptr is bit 0,
// find the first set bit, then un-rotate the offset back to a channel index.
module rr_priority_pick
  import pipelined_arb_mux_pkg::*;
#(
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              grant_vld,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  logic                found;
  int                  start;
  int                  off;
  int                  idx;

  always_comb begin
    start = (int'(ptr) >= NUM_IN - 1) ? 0 : int'(ptr) + 1;
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_IN-1:0];
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    // Wrap explicitly so a non-power-of-2 NUM_IN never yields idx >= NUM_IN.
    idx = start + off;
    if (idx >= NUM_IN) idx = idx - NUM_IN;
    grant_vld = found;
    grant_idx = SEL_W'(idx);
  end

endmodule

// File: rtl/pipelined_arb_mux.sv
// NUM_IN-channel valid/ready mux with explicit-select or round-robin grant,
// merged into one output register (1-cycle latency, 1 transfer/cycle).
module pipelined_arb_mux
  import pipelined_arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [NUM_IN-1:0] sel_dec;
  logic [NUM_IN-1:0] gnt_dec;
  logic [WIDTH-1:0]  lane_gated [NUM_IN];
  logic [WIDTH-1:0]  mux_data_p0;
  logic              sel_vld;
  logic              rr_vld;
  logic [SEL_W-1:0]  rr_idx;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic [SEL_W-1:0]  rr_ptr;
  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  sel_p1;

  rr_priority_pick #(.NUM_IN(NUM_IN)) u_rr_pick (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant_vld (rr_vld),
    .grant_idx (rr_idx)
  );

  // Decoded select never matches an index >= NUM_IN, so out-of-range sel grants nothing.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign sel_dec[i]    = (sel == SEL_W'(i));
    assign gnt_dec[i]    = grant_vld && (grant_idx == SEL_W'(i));
    assign lane_gated[i] = {WIDTH{gnt_dec[i]}} & in_data[lane_lsb(i, WIDTH) +: WIDTH];
  end

  assign sel_vld   = |(sel_dec & in_valid);
  assign grant_vld = (mode == MODE_RR) ? rr_vld : sel_vld;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign load_en   = !vld_p1 || out_ready;
  assign in_ready  = (rst_n && load_en) ? gnt_dec : '0;

  always_comb begin
    mux_data_p0 = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      mux_data_p0 = mux_data_p0 | lane_gated[k];
    end
  end

  // ---- p0 -> p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      rr_ptr  <= SEL_W'(NUM_IN - 1);
    end else if (load_en) begin
      if (grant_vld) begin
        vld_p1  <= 1'b1;
        data_p1 <= mux_data_p0;
        sel_p1  <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= grant_idx;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_pipelined_arb_mux.sv
// Scoreboard bench for pipelined_arb_mux: an 8-channel instance for the main
// scenarios and a 5-channel instance for non-power-of-2 round-robin.
module tb_pipelined_arb_mux;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         mode;
  logic [2:0]   sel;
  logic [7:0]   in_valid;
  logic [255:0] in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_ready;

  logic         mode5;
  logic [2:0]   sel5;
  logic [4:0]   in_valid5;
  logic [159:0] in_data5;
  logic [4:0]   in_ready5;
  logic         out_valid5;
  logic [31:0]  out_data5;
  logic [2:0]   out_sel5;
  logic         out_ready5;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];
  exp_t sbq5[$];

  always #5 clk = ~clk;

  pipelined_arb_mux #(.WIDTH(32), .NUM_IN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  pipelined_arb_mux #(.WIDTH(32), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_sel(out_sel5),
    .out_ready(out_ready5)
  );

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check8(input string name);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: output seen with empty scoreboard, out_data=%h", name, out_data);
    end else begin
      e = sbq.pop_front();
      if (out_valid !== 1'b1 || out_data !== e.d || out_sel !== e.s) begin
        miscompares++;
        $display("FAIL %s: got vld=%b data=%h sel=%0d, expected vld=1 data=%h sel=%0d",
                 name, out_valid, out_data, out_sel, e.d, e.s);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hA000_0000 + i;
    mode5 = 1'b1; sel5 = '0; in_valid5 = '0; in_data5 = '0; out_ready5 = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got vld=%b data=%h sel=%0d rdy=%h, expected 0/0/0/00",
               out_valid, out_data, out_sel, in_ready);
    end
    edge_step();
    edge_step();
  endtask

  task automatic test_mode0_pass();
    mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    in_data[5*32 +: 32] = 32'hDEADBEEF;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h20) begin
      miscompares++;
      $display("FAIL mode0_ready: got %h expected 20", in_ready);
    end
    sbq.push_back('{d: 32'hDEADBEEF, s: 3'd5});
    edge_step();
    pop_check8("mode0_data");
  endtask

  task automatic test_mode0_invalid();
    sel = 3'd3; in_valid = 8'hF7;
    #1;
    vectors++;
    if (in_ready !== 8'h00) begin
      miscompares++;
      $display("FAIL mode0_invalid_ready: got %h expected 00", in_ready);
    end
    edge_step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF || out_sel !== 3'd5) begin
      miscompares++;
      $display("FAIL mode0_drain: got vld=%b data=%h sel=%0d, expected 0/deadbeef/5",
               out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_rdy;
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = i;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_rdy = 8'h01 << (k % 8);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_ready[%0d]: got %h expected %h", k, in_ready, exp_rdy);
      end
      sbq.push_back('{d: 32'(k % 8), s: 3'(k % 8)});
      edge_step();
      pop_check8("rr_out");
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (in_ready !== 8'h00) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %h expected 00", k, in_ready);
      end
      edge_step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'd7 || out_sel !== 3'd7) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got vld=%b data=%h sel=%0d, expected 1/7/7",
                 k, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h01) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %h expected 01", in_ready);
    end
    sbq.push_back('{d: 32'd0, s: 3'd0});
    edge_step();
    pop_check8("stall_release_out");
  endtask

  task automatic test_reset_midstream();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got vld=%b data=%h sel=%0d rdy=%h, expected 0/0/0/00",
               out_valid, out_data, out_sel, in_ready);
    end
    edge_step();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 8'h01) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %h expected 01", in_ready);
    end
    sbq.push_back('{d: 32'd0, s: 3'd0});
    edge_step();
    pop_check8("post_reset_out");
  endtask

  task automatic test_sparse_rr5();
    exp_t e;
    logic [2:0] g;
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'b11111; out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = 32'h500 + i;
    #1;
    vectors++;
    if (in_ready5 !== 5'b00000) begin
      miscompares++;
      $display("FAIL sel_out_of_range_ready: got %b expected 00000", in_ready5);
    end
    edge_step();
    vectors++;
    if (out_valid5 !== 1'b0) begin
      miscompares++;
      $display("FAIL sel_out_of_range_vld: got %b expected 0", out_valid5);
    end
    mode5 = 1'b1; in_valid5 = 5'b10010;
    for (int k = 0; k < 6; k++) begin
      g = (k % 2 == 0) ? 3'd1 : 3'd4;
      #1;
      vectors++;
      if (in_ready5 !== (5'b00001 << g)) begin
        miscompares++;
        $display("FAIL rr5_ready[%0d]: got %b expected %b", k, in_ready5, 5'b00001 << g);
      end
      sbq5.push_back('{d: 32'h500 + 32'(g), s: g});
      edge_step();
      vectors++;
      if (sbq5.size() == 0) begin
        miscompares++;
        $display("FAIL rr5_out[%0d]: empty scoreboard, out_sel=%0d", k, out_sel5);
      end else begin
        e = sbq5.pop_front();
        if (out_valid5 !== 1'b1 || out_data5 !== e.d || out_sel5 !== e.s || out_sel5 >= 3'd5) begin
          miscompares++;
          $display("FAIL rr5_out[%0d]: got vld=%b data=%h sel=%0d, expected 1/%h/%0d",
                   k, out_valid5, out_data5, out_sel5, e.d, e.s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_pass();
    test_mode0_invalid();
    test_rr_fairness();
    test_back_pressure();
    test_reset_midstream();
    test_sparse_rr5();
    vectors++;
    if (sbq.size() != 0 || sbq5.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sbq.size(), sbq5.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
